fpu_issue_ctrl: RTL and testbench

Operation issue controller for the 8-bit FPU. It accepts one operation request at a time and latches the opcode and both operands. It presents them to the combinational exception module and samples the exception flag. On an exception it returns the canonical NaN directly; otherwise it dispatches the operation to the arithmetic datapath and waits for its result. It sits between the request source and the exception module plus arithmetic units, and guards against a hung datapath with a watchdog.

---
 rtl/fpu_issue_ctrl.sv | 154 +++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: accepts one FPU operation at a time, screens it through the
// external exception module, dispatches non-exceptional operations to the
// arithmetic datapath and returns exactly one response per accepted request.
// A watchdog bounds the time spent waiting for the datapath result.
module fpu_issue_ctrl #(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [7:0]  NAN_CANON      = 8'h7C
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_in0,
    input  logic [7:0] req_in1,
    output logic [1:0] exc_op,
    output logic [7:0] exc_in0,
    output logic [7:0] exc_in1,
    input  logic       exc_flag,
    output logic       alu_valid,
    input  logic       alu_ready,
    input  logic       alu_done,
    input  logic [7:0] alu_result,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_data,
    output logic       resp_exc,
    output logic       resp_timeout,
    output logic [7:0] op_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DISPATCH,
        S_WAIT,
        S_RESPOND
    } state_t;

    // The watchdog fires on the WAIT cycle in which the counter would reach
    // TIMEOUT_CYCLES, so the response appears exactly TIMEOUT_CYCLES cycles
    // after WAIT is entered.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state_reg;
    state_t     state_next;
    logic [7:0] wd_count_reg;
    logic       timeout_hit;

    logic [1:0] exc_op_reg;
    logic [7:0] exc_in0_reg;
    logic [7:0] exc_in1_reg;
    logic       resp_valid_reg;
    logic [7:0] resp_data_reg;
    logic       resp_exc_reg;
    logic       resp_timeout_reg;
    logic [7:0] op_count_reg;

    assign timeout_hit = (wd_count_reg == WD_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode; alu_done beats the watchdog when both happen together.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:     if (req_valid) state_next = S_CHECK;
            S_CHECK:    state_next = exc_flag ? S_RESPOND : S_DISPATCH;
            S_DISPATCH: if (alu_ready) state_next = S_WAIT;
            S_WAIT:     if (alu_done || timeout_hit) state_next = S_RESPOND;
            S_RESPOND:  if (resp_ready) state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state register.
    assign req_ready = (state_reg == S_IDLE);
    assign alu_valid = (state_reg == S_DISPATCH);

    // Operand latch, watchdog, response registers and completion counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_op_reg       <= 2'd0;
            exc_in0_reg      <= 8'd0;
            exc_in1_reg      <= 8'd0;
            wd_count_reg     <= 8'd0;
            resp_valid_reg   <= 1'b0;
            resp_data_reg    <= 8'd0;
            resp_exc_reg     <= 1'b0;
            resp_timeout_reg <= 1'b0;
            op_count_reg     <= 8'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        exc_op_reg  <= req_op;
                        exc_in0_reg <= req_in0;
                        exc_in1_reg <= req_in1;
                    end
                end
                S_CHECK: begin
                    if (exc_flag) begin
                        resp_data_reg  <= NAN_CANON;
                        resp_exc_reg   <= 1'b1;
                        resp_valid_reg <= 1'b1;
                    end
                end
                S_DISPATCH: begin
                    // Watchdog only measures datapath latency, not dispatch stalls.
                    if (alu_ready) begin
                        wd_count_reg <= 8'd0;
                    end
                end
                S_WAIT: begin
                    wd_count_reg <= wd_count_reg + 8'd1;
                    if (alu_done) begin
                        resp_data_reg  <= alu_result;
                        resp_valid_reg <= 1'b1;
                    end else if (timeout_hit) begin
                        resp_data_reg    <= NAN_CANON;
                        resp_timeout_reg <= 1'b1;
                        resp_valid_reg   <= 1'b1;
                    end
                end
                S_RESPOND: begin
                    if (resp_ready) begin
                        resp_valid_reg   <= 1'b0;
                        resp_exc_reg     <= 1'b0;
                        resp_timeout_reg <= 1'b0;
                        op_count_reg     <= op_count_reg + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign exc_op       = exc_op_reg;
    assign exc_in0      = exc_in0_reg;
    assign exc_in1      = exc_in1_reg;
    assign resp_valid   = resp_valid_reg;
    assign resp_data    = resp_data_reg;
    assign resp_exc     = resp_exc_reg;
    assign resp_timeout = resp_timeout_reg;
    assign op_count     = op_count_reg;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed testbench for fpu_issue_ctrl (instantiated with TIMEOUT_CYCLES=4).
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_fpu_issue_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_in0;
    logic [7:0] req_in1;
    logic [1:0] exc_op;
    logic [7:0] exc_in0;
    logic [7:0] exc_in1;
    logic       exc_flag;
    logic       alu_valid;
    logic       alu_ready;
    logic       alu_done;
    logic [7:0] alu_result;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_data;
    logic       resp_exc;
    logic       resp_timeout;
    logic [7:0] op_count;

    int errors;
    int checks;

    fpu_issue_ctrl #(.TIMEOUT_CYCLES(4), .NAN_CANON(8'h7C)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_in0(req_in0), .req_in1(req_in1),
        .exc_op(exc_op), .exc_in0(exc_in0), .exc_in1(exc_in1), .exc_flag(exc_flag),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_done(alu_done),
        .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_exc(resp_exc), .resp_timeout(resp_timeout), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns with the DUT in CHECK.
    task automatic send_req(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_in0   = a;
        req_in1   = b;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (req_ready !== 1'b1 || alu_valid !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: req_ready=%b alu_valid=%b resp_valid=%b want 1 0 0",
                     req_ready, alu_valid, resp_valid);
        end
        checks++;
        if (resp_data !== 8'h00 || resp_exc !== 1'b0 || resp_timeout !== 1'b0 || op_count !== 8'h00) begin
            errors++;
            $display("FAIL reset_resp: data=%h exc=%b to=%b cnt=%0d want 00 0 0 0",
                     resp_data, resp_exc, resp_timeout, op_count);
        end
        checks++;
        if (exc_op !== 2'd0 || exc_in0 !== 8'h00 || exc_in1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_exc: op=%0d in0=%h in1=%h want 0 00 00", exc_op, exc_in0, exc_in1);
        end
        $display("test_reset done");
    endtask

    task automatic test_exception();
        exc_flag = 1'b1;
        send_req(2'd0, 8'h79, 8'h00);      // now in CHECK
        checks++;
        if (req_ready !== 1'b0 || alu_valid !== 1'b0 || resp_valid !== 1'b0 || exc_in0 !== 8'h79) begin
            errors++;
            $display("FAIL exc_check_cycle: req_ready=%b alu_valid=%b resp_valid=%b exc_in0=%h want 0 0 0 79",
                     req_ready, alu_valid, resp_valid, exc_in0);
        end
        tick();                             // RESPOND, two cycles after accept
        exc_flag = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 8'h7C || resp_exc !== 1'b1 ||
            resp_timeout !== 1'b0 || alu_valid !== 1'b0) begin
            errors++;
            $display("FAIL exc_resp: valid=%b data=%h exc=%b to=%b alu_valid=%b want 1 7c 1 0 0",
                     resp_valid, resp_data, resp_exc, resp_timeout, alu_valid);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || resp_exc !== 1'b0 || op_count !== 8'd1 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL exc_done: valid=%b exc=%b cnt=%0d req_ready=%b want 0 0 1 1",
                     resp_valid, resp_exc, op_count, req_ready);
        end
        $display("test_exception done: data=%h cnt=%0d", resp_data, op_count);
    endtask

    task automatic test_normal();
        alu_ready = 1'b1;
        send_req(2'd0, 8'h38, 8'h38);      // cycle 1 after accept: CHECK
        tick();                             // cycle 2: DISPATCH
        checks++;
        if (alu_valid !== 1'b1 || exc_op !== 2'd0 || exc_in1 !== 8'h38) begin
            errors++;
            $display("FAIL norm_dispatch: alu_valid=%b exc_op=%0d exc_in1=%h want 1 0 38",
                     alu_valid, exc_op, exc_in1);
        end
        tick();                             // cycle 3: WAIT
        alu_ready  = 1'b0;
        checks++;
        if (alu_valid !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL norm_wait: alu_valid=%b resp_valid=%b want 0 0", alu_valid, resp_valid);
        end
        alu_done   = 1'b1;
        alu_result = 8'h40;
        tick();                             // cycle 4: RESPOND
        alu_done   = 1'b0;
        alu_result = 8'h00;
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 8'h40 || resp_exc !== 1'b0 || resp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL norm_resp: valid=%b data=%h exc=%b to=%b want 1 40 0 0",
                     resp_valid, resp_data, resp_exc, resp_timeout);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checks++;
        if (op_count !== 8'd2 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL norm_done: cnt=%0d valid=%b want 2 0", op_count, resp_valid);
        end
        $display("test_normal done: cnt=%0d", op_count);
    endtask

    task automatic test_backpressure();
        alu_ready = 1'b0;
        send_req(2'd2, 8'h40, 8'h48);
        tick();                             // DISPATCH
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (alu_valid !== 1'b1 || resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_alu_stall[%0d]: alu_valid=%b resp_valid=%b want 1 0",
                         i, alu_valid, resp_valid);
            end
            tick();
        end
        alu_ready = 1'b1;
        tick();                             // WAIT entered; watchdog starts from zero
        alu_ready = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++;
            if (resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_early_timeout[%0d]: resp_valid=%b want 0", i, resp_valid);
            end
        end
        tick();                             // 4th WAIT cycle expires
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 8'h7C || resp_timeout !== 1'b1 || resp_exc !== 1'b0) begin
            errors++;
            $display("FAIL bp_timeout: valid=%b data=%h to=%b exc=%b want 1 7c 1 0",
                     resp_valid, resp_data, resp_timeout, resp_exc);
        end
        // Hold off the response with a new request pending; nothing may change.
        req_valid = 1'b1;
        req_op    = 2'd3;
        req_in0   = 8'h11;
        req_in1   = 8'h22;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== 8'h7C || resp_timeout !== 1'b1 ||
                req_ready !== 1'b0 || exc_in0 !== 8'h40) begin
                errors++;
                $display("FAIL bp_resp_stall[%0d]: valid=%b data=%h to=%b req_ready=%b exc_in0=%h want 1 7c 1 0 40",
                         i, resp_valid, resp_data, resp_timeout, req_ready, exc_in0);
            end
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checks++;
        if (op_count !== 8'd3 || resp_timeout !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_done: cnt=%0d to=%b valid=%b want 3 0 0", op_count, resp_timeout, resp_valid);
        end
        $display("test_backpressure done: cnt=%0d", op_count);
    endtask

    task automatic test_done_at_timeout();
        alu_ready = 1'b1;
        send_req(2'd1, 8'h48, 8'h38);
        tick();                             // DISPATCH
        tick();                             // WAIT
        alu_ready = 1'b0;
        tick();
        tick();
        tick();                             // three WAIT cycles with no result
        alu_done   = 1'b1;
        alu_result = 8'h55;
        tick();                             // result on the 4th WAIT cycle
        alu_done   = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 8'h55 || resp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL done_vs_timeout: valid=%b data=%h to=%b want 1 55 0",
                     resp_valid, resp_data, resp_timeout);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checks++;
        if (op_count !== 8'd4) begin
            errors++;
            $display("FAIL done_vs_timeout_cnt: cnt=%0d want 4", op_count);
        end
        $display("test_done_at_timeout done: cnt=%0d", op_count);
    endtask

    task automatic test_reset_mid_wait();
        alu_ready = 1'b1;
        send_req(2'd0, 8'h38, 8'h40);
        tick();                             // DISPATCH
        tick();                             // WAIT
        alu_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || op_count !== 8'd0 || req_ready !== 1'b1 || alu_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: valid=%b cnt=%0d req_ready=%b alu_valid=%b want 0 0 1 0",
                     resp_valid, op_count, req_ready, alu_valid);
        end
        tick();
        rst_n = 1'b1;
        alu_done   = 1'b1;                  // stale result must be ignored
        alu_result = 8'h99;
        tick();
        alu_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL rst_dropped[%0d]: valid=%b req_ready=%b want 0 1", i, resp_valid, req_ready);
            end
            tick();
        end
        $display("test_reset_mid_wait done");
    endtask

    task automatic test_wrap();
        exc_flag   = 1'b1;
        resp_ready = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            send_req(2'd3, 8'h7F, 8'h00);  // CHECK
            tick();                         // RESPOND
            tick();                         // handshake back to IDLE
            if (i == 255) begin
                checks++;
                if (op_count !== 8'd255) begin
                    errors++;
                    $display("FAIL wrap_255: cnt=%0d want 255", op_count);
                end
            end
        end
        checks++;
        if (op_count !== 8'd0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL wrap_256: cnt=%0d req_ready=%b want 0 1", op_count, req_ready);
        end
        exc_flag   = 1'b0;
        resp_ready = 1'b0;
        $display("test_wrap done: cnt=%0d", op_count);
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'd0;
        req_in0    = 8'h00;
        req_in1    = 8'h00;
        exc_flag   = 1'b0;
        alu_ready  = 1'b0;
        alu_done   = 1'b0;
        alu_result = 8'h00;
        resp_ready = 1'b0;
        test_reset();
        test_exception();
        test_normal();
        test_backpressure();
        test_done_at_timeout();
        test_reset_mid_wait();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
